// File: rtl/adder_share_seq_pkg.sv
// Shared types and constants for the two-requester shared-adder sequencer.
package adder_share_seq_pkg;

   localparam int unsigned WORD_W  = 16;
   localparam int unsigned NUM_REQ = 2;

   typedef enum logic {
      IDLE,
      LOCKED
   } state_e;

   typedef struct packed {
      logic              id;
      logic [WORD_W-1:0] sum;
      logic              last;
      logic              cout;
      logic              ovf;
      logic              err;
   } rsp_t;

endpackage

// File: rtl/adder_share_seq_rr_arb2.sv
// Two-requester round-robin arbiter with transaction lock; produces a one-hot grant.
module rr_arb2
   import adder_share_seq_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic               i_rr,
   input  logic               i_lock,
   input  logic               i_owner,
   output logic [NUM_REQ-1:0] o_grant
);

   always_comb begin
      o_grant = '0;
      if (i_lock) begin
         // Only the owner may proceed; a bubble from the owner grants nobody.
         o_grant[i_owner] = i_valid[i_owner];
      end else if (&i_valid) begin
         o_grant[i_rr] = 1'b1;
      end else begin
         o_grant = i_valid;
      end
   end

endmodule

// File: rtl/adder_share_seq.sv
// Shares one external combinational adder between two multi-word requesters,
// chaining carry across words and registering each sum on a valid/ready port.
module adder_share_seq
   import adder_share_seq_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   output logic [NUM_REQ-1:0]   o_req_ready,
   input  logic [WORD_W-1:0]    i_req_a0,
   input  logic [WORD_W-1:0]    i_req_a1,
   input  logic [WORD_W-1:0]    i_req_b0,
   input  logic [WORD_W-1:0]    i_req_b1,
   input  logic [NUM_REQ-1:0]   i_req_last,
   output logic [WORD_W-1:0]    o_add_a,
   output logic [WORD_W-1:0]    o_add_b,
   output logic                 o_add_cin,
   input  logic [WORD_W-1:0]    i_add_sum,
   input  logic                 i_add_cout,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic                 o_rsp_id,
   output logic [WORD_W-1:0]    o_rsp_sum,
   output logic                 o_rsp_last,
   output logic                 o_rsp_cout,
   output logic                 o_rsp_ovf,
   output logic                 o_rsp_err
);

   localparam logic [7:0] LastCnt = 8'(MAX_WORDS - 1);

   state_e     r_state, w_state_nxt;
   logic       r_owner, w_owner_nxt;
   logic       r_rr, w_rr_nxt;
   logic       r_carry, w_carry_nxt;
   logic [7:0] r_wcnt, w_wcnt_nxt;
   logic       r_rsp_valid, w_rsp_valid_nxt;
   rsp_t       r_rsp, w_rsp_nxt;

   logic [NUM_REQ-1:0] w_arb_gnt;
   logic [NUM_REQ-1:0] w_gnt;
   logic               w_space;
   logic               w_any_gnt;
   logic               w_acc;
   logic               w_sel;
   logic [WORD_W-1:0]  w_a;
   logic [WORD_W-1:0]  w_b;
   logic               w_last_eff;

   rr_arb2 u_arb (
      .i_valid (i_req_valid),
      .i_rr    (r_rr),
      .i_lock  (r_state == LOCKED),
      .i_owner (r_owner),
      .o_grant (w_arb_gnt)
   );

   // Gating with reset keeps every output quiet while rst_n is held low.
   assign w_gnt       = w_arb_gnt & {NUM_REQ{i_rst_n}};
   assign w_space     = !r_rsp_valid || i_rsp_ready;
   assign o_req_ready = w_gnt & {NUM_REQ{w_space}};
   assign w_any_gnt   = |w_gnt;
   assign w_acc       = |o_req_ready;
   assign w_sel       = w_gnt[1];

   assign w_a = w_sel ? i_req_a1 : i_req_a0;
   assign w_b = w_sel ? i_req_b1 : i_req_b0;

   assign o_add_a   = w_any_gnt ? w_a : '0;
   assign o_add_b   = w_any_gnt ? w_b : '0;
   assign o_add_cin = w_any_gnt && (r_state == LOCKED) && r_carry;

   assign w_last_eff = i_req_last[w_sel] || (r_wcnt == LastCnt);

   always_comb begin
      w_state_nxt     = r_state;
      w_owner_nxt     = r_owner;
      w_rr_nxt        = r_rr;
      w_carry_nxt     = r_carry;
      w_wcnt_nxt      = r_wcnt;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_nxt       = r_rsp;

      if (w_acc) begin
         w_rsp_valid_nxt = 1'b1;
         w_rsp_nxt.id    = w_sel;
         w_rsp_nxt.sum   = i_add_sum;
         w_rsp_nxt.last  = w_last_eff;
         w_rsp_nxt.cout  = i_add_cout;
         w_rsp_nxt.ovf   = (w_a[WORD_W-1] == w_b[WORD_W-1]) &&
                           (i_add_sum[WORD_W-1] != w_a[WORD_W-1]);
         w_rsp_nxt.err   = w_last_eff && !i_req_last[w_sel];
         if (w_last_eff) begin
            w_state_nxt = IDLE;
            w_carry_nxt = 1'b0;
            w_wcnt_nxt  = '0;
            w_rr_nxt    = ~w_sel;
         end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_sel;
            w_carry_nxt = i_add_cout;
            w_wcnt_nxt  = r_wcnt + 8'd1;
         end
      end else if (i_rsp_ready) begin
         w_rsp_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_owner     <= 1'b0;
         r_rr        <= 1'b0;
         r_carry     <= 1'b0;
         r_wcnt      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_rr        <= w_rr_nxt;
         r_carry     <= w_carry_nxt;
         r_wcnt      <= w_wcnt_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp       <= w_rsp_nxt;
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp.id;
   assign o_rsp_sum   = r_rsp.sum;
   assign o_rsp_last  = r_rsp.last;
   assign o_rsp_cout  = r_rsp.cout;
   assign o_rsp_ovf   = r_rsp.ovf;
   assign o_rsp_err   = r_rsp.err;

endmodule

// File: tb/tb_adder_share_seq.sv
// Directed bench for adder_share_seq; the external adder is modelled as a plain 16-bit add.
module tb_adder_share_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a0, req_a1, req_b0, req_b1;
   logic [1:0]  req_last;
   logic [15:0] add_a, add_b, add_sum;
   logic        add_cin, add_cout;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_last, rsp_cout, rsp_ovf, rsp_err;
   logic [15:0] rsp_sum;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

   adder_share_seq #(.MAX_WORDS(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a0    (req_a0),
      .i_req_a1    (req_a1),
      .i_req_b0    (req_b0),
      .i_req_b1    (req_b1),
      .i_req_last  (req_last),
      .o_add_a     (add_a),
      .o_add_b     (add_b),
      .o_add_cin   (add_cin),
      .i_add_sum   (add_sum),
      .i_add_cout  (add_cout),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_id    (rsp_id),
      .o_rsp_sum   (rsp_sum),
      .o_rsp_last  (rsp_last),
      .o_rsp_cout  (rsp_cout),
      .o_rsp_ovf   (rsp_ovf),
      .o_rsp_err   (rsp_err)
   );

   // Packed response view: {valid, id, sum, last, cout, ovf, err}
   logic [21:0] rsp_vec;
   assign rsp_vec = {rsp_valid, rsp_id, rsp_sum, rsp_last, rsp_cout, rsp_ovf, rsp_err};

   function automatic logic [21:0] exp_rsp(input logic id, input logic [15:0] sum,
                                           input logic last, input logic cout,
                                           input logic ovf, input logic err);
      return {1'b1, id, sum, last, cout, ovf, err};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [21:0] held;
      logic [1:0]  exp_gnt [4];
      exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;

      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_last  = 2'b00;
      req_a0 = 16'h1234; req_b0 = 16'h1111; req_a1 = 16'h4321; req_b1 = 16'h2222;
      rsp_ready = 1'b1;
      #12;
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_rsp", 32'(rsp_vec), 32'd0);
      chk("reset_add_a", 32'(add_a), 32'd0);
      req_valid = 2'b00;
      rst_n     = 1'b1;
      tick();

      // Single word from req0 with signed overflow
      req_valid = 2'b01; req_last = 2'b01; req_a0 = 16'h7FFF; req_b0 = 16'h0001;
      #1;
      chk("t1_ready", 32'(req_ready), 32'h1);
      chk("t1_cin", 32'(add_cin), 32'h0);
      tick();
      req_valid = 2'b00;
      chk("t1_rsp", 32'(rsp_vec), 32'(exp_rsp(1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0)));

      // Two-word transaction from req1
      req_valid = 2'b10; req_last = 2'b00; req_a1 = 16'hFFFF; req_b1 = 16'h0001;
      #1;
      chk("t2_ready_w0", 32'(req_ready), 32'h2);
      chk("t2_cin_w0", 32'(add_cin), 32'h0);
      tick();
      chk("t2_rsp_w0", 32'(rsp_vec), 32'(exp_rsp(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0)));
      req_last = 2'b10; req_a1 = 16'h0000; req_b1 = 16'h0000;
      #1;
      chk("t2_cin_w1", 32'(add_cin), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("t2_rsp_w1", 32'(rsp_vec), 32'(exp_rsp(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0)));

      // Both requesters with single-word ops alternate
      req_valid = 2'b11; req_last = 2'b11;
      req_a0 = 16'h0001; req_b0 = 16'h0001; req_a1 = 16'h0002; req_b1 = 16'h0002;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t3_grant%0d", i), 32'(req_ready), 32'(exp_gnt[i]));
         tick();
         chk($sformatf("t3_rsp%0d", i), 32'(rsp_vec),
             32'(exp_rsp(exp_gnt[i][1], exp_gnt[i][1] ? 16'h0004 : 16'h0002,
                         1'b1, 1'b0, 1'b0, 1'b0)));
      end

      // req0 three-word transaction with a bubble while req1 waits
      req_valid = 2'b11; req_last = 2'b10;
      req_a0 = 16'h0001; req_b0 = 16'h0002; req_a1 = 16'h0005; req_b1 = 16'h0005;
      #1;
      chk("t4_ready_w0", 32'(req_ready), 32'h1);
      tick();
      chk("t4_rsp_w0", 32'(rsp_vec), 32'(exp_rsp(1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0)));
      req_a0 = 16'h8000; req_b0 = 16'h8000;
      #1;
      chk("t4_ready_w1", 32'(req_ready), 32'h1);
      tick();
      chk("t4_rsp_w1", 32'(rsp_vec), 32'(exp_rsp(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0)));
      req_valid = 2'b10;
      #1;
      chk("t4_bubble_ready", 32'(req_ready), 32'h0);
      tick();
      chk("t4_bubble_drain", 32'(rsp_valid), 32'h0);
      req_valid = 2'b11; req_last = 2'b11; req_a0 = 16'h0000; req_b0 = 16'h0000;
      #1;
      chk("t4_ready_w2", 32'(req_ready), 32'h1);
      chk("t4_cin_w2", 32'(add_cin), 32'h1);
      tick();
      chk("t4_rsp_w2", 32'(rsp_vec), 32'(exp_rsp(1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0)));
      #1;
      chk("t4_req1_next", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      chk("t4_rsp_req1", 32'(rsp_vec), 32'(exp_rsp(1'b1, 16'h000A, 1'b1, 1'b0, 1'b0, 1'b0)));

      // Truncation at MAX_WORDS=8 with carry chained through every word
      req_valid = 2'b01; req_last = 2'b00; req_a0 = 16'hFFFF; req_b0 = 16'h0001;
      tick();
      chk("t5_rsp_w0", 32'(rsp_vec), 32'(exp_rsp(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0)));
      for (int i = 1; i < 7; i++) tick();
      chk("t5_rsp_w6", 32'(rsp_vec), 32'(exp_rsp(1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0)));
      tick();
      chk("t5_rsp_w7", 32'(rsp_vec), 32'(exp_rsp(1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1)));
      req_last = 2'b01;
      #1;
      chk("t5_cin_w8", 32'(add_cin), 32'h0);
      tick();
      req_valid = 2'b00;
      chk("t5_rsp_w8", 32'(rsp_vec), 32'(exp_rsp(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0)));

      // Back-pressure mid-transaction from req1
      req_valid = 2'b10; req_last = 2'b00; req_a1 = 16'hFFFF; req_b1 = 16'h0001;
      tick();
      held = exp_rsp(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6_rsp_w0", 32'(rsp_vec), 32'(held));
      rsp_ready = 1'b0; req_last = 2'b10; req_a1 = 16'h0000; req_b1 = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t6_bp_ready%0d", i), 32'(req_ready), 32'h0);
         tick();
         chk($sformatf("t6_bp_hold%0d", i), 32'(rsp_vec), 32'(held));
      end
      rsp_ready = 1'b1;
      #1;
      chk("t6_ready_resume", 32'(req_ready), 32'h2);
      chk("t6_cin_resume", 32'(add_cin), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("t6_rsp_w1", 32'(rsp_vec), 32'(exp_rsp(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0)));

      // Reset pulsed mid-transaction discards the carry
      req_valid = 2'b01; req_last = 2'b00; req_a0 = 16'hFFFF; req_b0 = 16'h0001;
      tick();
      rst_n = 1'b0;
      #1;
      chk("t7_rst_ready", 32'(req_ready), 32'h0);
      chk("t7_rst_rsp", 32'(rsp_vec), 32'h0);
      chk("t7_rst_add", 32'({add_a, add_cin}), 32'h0);
      rst_n = 1'b1;
      req_last = 2'b01; req_a0 = 16'h0005; req_b0 = 16'h0003;
      #1;
      chk("t7_ready_new", 32'(req_ready), 32'h1);
      chk("t7_cin_new", 32'(add_cin), 32'h0);
      tick();
      req_valid = 2'b00;
      chk("t7_rsp_new", 32'(rsp_vec), 32'(exp_rsp(1'b0, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0)));

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adder_share_seq.md
# adder_share_seq

Sequencer and arbiter that shares one external 16-bit combinational adder between two requesters. Each requester issues single- or multi-word (multi-precision) additions as a stream of 16-bit word pairs, least-significant word first. The block:
- chains the carry between words;
- locks the adder to one requester for the whole transaction;
- returns registered sums on a valid/ready response port.

It sits between the requesting engines and the adder datapath.

## Interface
- MAX_WORDS, 8: max words per transaction; range 2..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester word valid.
- req_ready  out  2  per-requester word accepted this cycle.
- req_a0, req_a1  in  16 each  operand A word, requester 0/1.
- req_b0, req_b1  in  16 each  operand B word, requester 0/1.
- req_last  in  2  word is most-significant (final) word of transaction.
- add_a, add_b  out  16  operands to adder.
- add_cin  out  1  carry into adder.
- add_sum  in  16  adder sum (combinational from add_a/add_b/add_cin).
- add_cout  in  1  adder carry out.
- rsp_valid  out  1  response register holds a word.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that produced the word.
- rsp_sum  out  16  sum word.
- rsp_last  out  1  final word of transaction.
- rsp_cout  out  1  unsigned carry out; meaningful only with rsp_last.
- rsp_ovf  out  1  signed overflow; meaningful only with rsp_last.
- rsp_err  out  1  transaction truncated at MAX_WORDS.

## Operation
- States: IDLE (no owner) and LOCKED (owner holds adder mid-transaction).
- Free slot: space = !rsp_valid || rsp_ready.
- IDLE grant:
  - Grant to the single valid requester.
  - If both are valid, grant to the round-robin pointer rr.
  - req_ready[g] = space.
  - Non-granted ready = 0.
- LOCKED grant: only the owner may be granted; req_ready[owner] = space; the other requester's ready = 0.
- Adder drive:
  - add_a/add_b = granted requester's operands.
  - add_cin = carry_q in LOCKED, 0 in IDLE.
  - When no grant, add_a/add_b/add_cin = 0.
- Accepting a word (valid & ready):
  - Response register loads sum, id, cout, ovf and last_eff.
  - last_eff = req_last | (wcnt == MAX_WORDS-1).
  - rsp_err = last_eff & !req_last.
- Signed overflow: ovf = (a[15]==b[15]) & (sum[15]!=a[15]).
- Non-last accept: go to LOCKED (owner = g); carry_q <= add_cout; wcnt++.
- Last accept: go to IDLE; carry_q <= 0; wcnt <= 0; rr <= ~g.
- wcnt counts words accepted in the current transaction (8 bits).
- Reset mid-transaction: the lock is dropped and all partial state is discarded; the requester restarts the transaction.

## Timing
- Reset values:
  - req_ready = 0 while rst_n is low.
  - rsp_valid, rsp_id, rsp_sum, rsp_last, rsp_cout, rsp_ovf, rsp_err = 0.
  - State = IDLE, rr = 0, carry_q = 0, wcnt = 0.
- req_ready is combinational from state, rr, req_valid, rsp_valid and rsp_ready. It never depends on add_sum.
- Latency: a word accepted in cycle N appears on rsp_* in cycle N+1.
- Throughput: one word per cycle when rsp_ready is held high.
- Back-pressure: while rsp_valid & !rsp_ready, all req_ready = 0 and rsp_* hold stable.
- Simultaneous rsp drain and accept in the same cycle: the response register reloads with no bubble.
- Single-word transaction (req_last on first word): cin = 0; no LOCKED cycle; rr flips.
- In LOCKED, a bubble (owner valid low) holds carry_q and wcnt unchanged; the other requester stays blocked.

## Structure
- Shared package holds:
  - WORD_W = 16 and NUM_REQ = 2;
  - the state enum {IDLE, LOCKED};
  - the response struct (id, sum, last, cout, ovf, err).
- One natural sub-module: rr_arb2, the two-requester round-robin arbiter taking valid, rr and lock/owner and producing the one-hot grant.
- The adder stays external.

## Test plan
- Single word from req0, a=0x7FFF, b=0x0001, last=1:
  - next cycle: rsp_sum=0x8000, rsp_cout=0, rsp_ovf=1, rsp_id=0, rsp_last=1.
- Two-word from req1 with rsp_ready held high:
  - words (0xFFFF,0x0001) then (0x0000,0x0000,last);
  - expected responses: 0x0000 with last=0, then 0x0001 with last=1, cout=0;
  - add_cin=1 on the second word.
- Both requesters valid with single-word ops after reset:
  - grant order 0,1,0,1;
  - no requester is granted twice while the other waits.
- req0 sends a 3-word transaction while req1 stays valid:
  - req_ready[1]=0 until req0's last word is accepted;
  - req1 is granted the next cycle.
- MAX_WORDS=8 and req0 never asserts last:
  - 8th word returns rsp_last=1, rsp_err=1;
  - state returns to IDLE and the 9th word starts with cin=0.
- Mid-transaction tests:
  - rsp_ready low for 3 cycles mid-transaction: rsp_* stable, all req_ready=0, and resuming yields the correct chained sum;
  - rst_n pulsed mid-transaction: all outputs 0 and a new transaction computes with cin=0.
